// File: rtl/marv32_instruction_fetch_buffer.sv
// marv32 fetch stage: issues word reads over req/gnt/rvalid and queues {instr, pc}
// in a DEPTH-entry FIFO that feeds the decoder, with branch redirect and response discard.
module marv32_instruction_fetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        ready_in,
  input  logic        branch_taken_in,
  input  logic [31:0] branch_pc_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_gnt_in,
  input  logic        imem_rvalid_in,
  input  logic [31:0] imem_rdata_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid_out,
  output logic        flush_out
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0] CNT_ZERO  = (AW+1)'(0);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW-1:0] PTR_ZERO = AW'(0);

  typedef enum logic [1:0] {
    ST_REQ     = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic          req_r;
  logic [31:0]   fetch_pc_r;
  logic [31:0]   target_pc_s;
  logic [31:0]   instr_mem_r [DEPTH];
  logic [31:0]   pc_mem_r    [DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [AW:0]   count_r;
  logic [AW:0]   count_nxt_s;
  logic          gnt_s;
  logic          push_s;
  logic          pop_s;
  logic          head_valid_s;

  assign target_pc_s  = branch_pc_in & 32'hFFFF_FFFC;
  assign gnt_s        = req_r & imem_gnt_in;
  assign push_s       = (state_r == ST_WAIT) & imem_rvalid_in & ~branch_taken_in;
  assign head_valid_s = (count_r != CNT_ZERO) & ~branch_taken_in;
  assign pop_s        = head_valid_s & ready_in;

  assign imem_req_out  = req_r;
  assign imem_addr_out = fetch_pc_r;

  // Next FSM state; a redirect overrides normal sequencing and decides whether a response is still owed.
  always_comb begin
    state_nxt_s = state_r;
    if (branch_taken_in) begin
      case (state_r)
        ST_REQ:     state_nxt_s = gnt_s ? ST_DISCARD : ST_REQ;
        ST_WAIT:    state_nxt_s = imem_rvalid_in ? ST_REQ : ST_DISCARD;
        ST_DISCARD: state_nxt_s = imem_rvalid_in ? ST_REQ : ST_DISCARD;
        default:    state_nxt_s = ST_REQ;
      endcase
    end else begin
      case (state_r)
        ST_REQ:     state_nxt_s = gnt_s ? ST_WAIT : ST_REQ;
        ST_WAIT:    state_nxt_s = imem_rvalid_in ? ST_REQ : ST_WAIT;
        ST_DISCARD: state_nxt_s = imem_rvalid_in ? ST_REQ : ST_DISCARD;
        default:    state_nxt_s = ST_REQ;
      endcase
    end
  end

  // Next FIFO occupancy.
  always_comb begin
    count_nxt_s = count_r;
    if (branch_taken_in) begin
      count_nxt_s = CNT_ZERO;
    end else if (push_s && !pop_s) begin
      count_nxt_s = count_r + CNT_ONE;
    end else if (pop_s && !push_s) begin
      count_nxt_s = count_r - CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Fetch FSM with registered request: req only when the response is guaranteed a free slot.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r    <= ST_REQ;
      req_r      <= 1'b0;
      fetch_pc_r <= RESET_PC;
    end else begin
      state_r <= state_nxt_s;
      req_r   <= (state_nxt_s == ST_REQ) && (count_nxt_s < DEPTH_CNT);
      if (branch_taken_in) begin
        fetch_pc_r <= target_pc_s;
      end else if (gnt_s) begin
        fetch_pc_r <= fetch_pc_r + 32'd4;
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rd_ptr_r <= PTR_ZERO;
      wr_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      count_r <= count_nxt_s;
      if (branch_taken_in) begin
        rd_ptr_r <= PTR_ZERO;
        wr_ptr_r <= PTR_ZERO;
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_ONE;
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
      end
    end
  end

  // FIFO storage; in WAIT fetch_pc_r has already advanced past the outstanding word.
  always_ff @(posedge clk_in) begin
    if (push_s) begin
      instr_mem_r[wr_ptr_r] <= imem_rdata_in;
      pc_mem_r[wr_ptr_r]    <= fetch_pc_r - 32'd4;
    end
  end

  // Decoder-facing outputs: head of FIFO, or a NOP bubble when empty or redirecting.
  always_comb begin
    instr_out       = NOP_INSTR;
    pc_out          = 32'h0000_0000;
    instr_valid_out = 1'b0;
    flush_out       = 1'b1;
    if (head_valid_s) begin
      instr_out       = instr_mem_r[rd_ptr_r];
      pc_out          = pc_mem_r[rd_ptr_r];
      instr_valid_out = 1'b1;
      flush_out       = 1'b0;
    end else begin
      instr_out       = NOP_INSTR;
      pc_out          = 32'h0000_0000;
      instr_valid_out = 1'b0;
      flush_out       = 1'b1;
    end
  end

endmodule

// File: tb/tb_marv32_instruction_fetch_buffer.sv
// Scoreboard bench for marv32_instruction_fetch_buffer: a behavioural memory drives the
// bus, the expected instruction stream is queued per redirect and popped by a monitor.
module tb_marv32_instruction_fetch_buffer;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, ready, branch, gnt, rvalid;
  logic [31:0] branch_pc, rdata;
  logic        req, valid, flush;
  logic [31:0] addr, instr, pc;

  logic        ready2, branch2, gnt2, rvalid2;
  logic [31:0] branch_pc2, rdata2;
  logic        req2, valid2, flush2;
  logic [31:0] addr2, instr2, pc2;

  marv32_instruction_fetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .ready_in(ready), .branch_taken_in(branch),
    .branch_pc_in(branch_pc), .imem_req_out(req), .imem_addr_out(addr),
    .imem_gnt_in(gnt), .imem_rvalid_in(rvalid), .imem_rdata_in(rdata),
    .instr_out(instr), .pc_out(pc), .instr_valid_out(valid), .flush_out(flush));

  marv32_instruction_fetch_buffer #(.DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk_in(clk), .rst_n_in(rst_n), .ready_in(ready2), .branch_taken_in(branch2),
    .branch_pc_in(branch_pc2), .imem_req_out(req2), .imem_addr_out(addr2),
    .imem_gnt_in(gnt2), .imem_rvalid_in(rvalid2), .imem_rdata_in(rdata2),
    .instr_out(instr2), .pc_out(pc2), .instr_valid_out(valid2), .flush_out(flush2));

  int checks = 0;
  int errors = 0;
  int pops = 0;
  int grants = 0;
  int rvalid_cnt = 0;
  int gnt_pct, lat_min, lat_max, pend_lat;
  logic        pend, poison, hold_valid, pend2;
  logic [31:0] pend_addr, hold_addr, exp_fetch;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  logic [31:0] d2_addr [2];
  int          d2_n = 0;

  // Memory contents: two fixed words at 0x0/0x4, a bijective hash elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h0050_0093;
    else if (a == 32'h0000_0004) return 32'h00A0_0113;
    else return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Expected program order from a start PC: consecutive words, nothing else.
  task automatic load_model(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 256; i++)
      exp_q.push_back({start + 32'(4 * i), mem_word(start + 32'(4 * i))});
    exp_fetch = start;
  endtask

  // One clock of the memory model; also tracks the expected fetch address stream.
  task automatic tick();
    logic g, r, req_s;
    logic [31:0] a, a2;
    r = pend && (pend_lat == 0);
    rvalid = r;
    rdata = r ? (poison ? 32'hDEAD_BEEF : mem_word(pend_addr)) : 32'h0000_0000;
    req_s = (req === 1'b1);
    if (req_s) chk("one_outstanding", pend, 1'b0);
    if (hold_valid) chk("addr_hold", {req, addr}, {1'b1, hold_addr});
    g = req_s && ($urandom_range(99) < gnt_pct);
    gnt = g;
    a = addr;
    gnt2 = req2;
    rvalid2 = pend2;
    rdata2 = NOP;
    a2 = addr2;
    @(posedge clk);
    if (r) begin
      pend = 1'b0;
      poison = 1'b0;
      rvalid_cnt++;
    end else if (pend && pend_lat > 0) begin
      pend_lat--;
    end
    if (g) begin
      chk("fetch_addr", a, exp_fetch);
      exp_fetch += 32'd4;
      pend = 1'b1;
      pend_addr = a;
      pend_lat = $urandom_range(lat_max, lat_min);
      grants++;
    end
    if (branch && rst_n) load_model(branch_pc & 32'hFFFF_FFFC);
    hold_valid = req_s && !g && !branch && rst_n;
    hold_addr = a;
    pend2 = gnt2;
    if (gnt2 && d2_n < 2) begin
      d2_addr[d2_n] = a2;
      d2_n++;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ready = 1'b0;
    branch = 1'b0;
    hold_valid = 1'b0;
    #1;
    chk("reset_ctrl", {req, valid, flush}, {1'b0, 1'b0, 1'b1});
    chk("reset_addr", addr, 32'h0000_0000);
    chk("reset_instr_pc", {instr, pc}, {NOP, 32'h0});
    repeat (3) tick();
    load_model(32'h0000_0000);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (valid !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    chk("wait_valid", valid, 1'b1);
  endtask

  // Monitor: every accepted instruction is compared with the head of the expected stream.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("flush_vs_valid", flush, !valid);
      if (branch) chk("redirect_bubble", {valid, instr}, {1'b0, NOP});
      if (!valid) begin
        chk("empty_outputs", {instr, pc}, {NOP, 32'h0});
      end else if (ready && !branch) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_underflow actual_pc=%0h expected=none", pc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pop_pc", pc, mon_e[63:32]);
          chk("pop_instr", instr, mon_e[31:0]);
          pops++;
        end
      end
    end
  end

  initial begin
    int n, g0, r0, p0, since;
    rst_n = 1'b0; ready = 1'b0; branch = 1'b0; branch_pc = 32'h0;
    gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    ready2 = 1'b1; branch2 = 1'b0; branch_pc2 = 32'h0;
    gnt2 = 1'b0; rvalid2 = 1'b0; rdata2 = 32'h0;
    gnt_pct = 100; lat_min = 0; lat_max = 0; pend_lat = 0;
    pend = 1'b0; poison = 1'b0; hold_valid = 1'b0; pend2 = 1'b0;
    pend_addr = 32'h0; hold_addr = 32'h0;
    d2_addr[0] = 32'h0; d2_addr[1] = 32'h0;
    load_model(32'h0);
    #2;

    // Reset latency and first two words.
    do_reset();
    ready = 1'b1;
    wait_valid(10, n);
    chk("reset_latency", n, 3);
    chk("first_instr", instr, 32'h0050_0093);
    chk("first_pc", pc, 32'h0);
    tick();
    wait_valid(10, n);
    chk("second_instr", instr, 32'h00A0_0113);
    chk("second_pc", pc, 32'h4);
    chk("second_flush", flush, 1'b0);
    repeat (4) tick();

    // Decoder stalled: exactly DEPTH grants, then req drops until a pop.
    do_reset();
    g0 = grants;
    repeat (12) tick();
    chk("stall_grants", grants - g0, 4);
    chk("stall_req", req, 1'b0);
    chk("stall_head", {valid, pc}, {1'b1, 32'h0});
    ready = 1'b1;
    tick();
    chk("req_after_pop", req, 1'b1);
    repeat (10) tick();

    // Redirect while WAIT; the late response carries a poison word.
    do_reset();
    ready = 1'b1;
    lat_min = 1; lat_max = 1;
    g0 = grants; n = 0;
    while (grants == g0 && n < 10) begin
      tick();
      n++;
    end
    chk("got_grant", grants - g0, 1);
    branch = 1'b1; branch_pc = 32'h0000_0100; poison = 1'b1;
    #1;
    chk("bubble_outputs", {flush, valid, instr}, {1'b1, 1'b0, NOP});
    lat_min = 0; lat_max = 0;
    tick();
    branch = 1'b0;
    chk("discard_bubble", {flush, valid}, {1'b1, 1'b0});
    wait_valid(10, n);
    chk("redirect_pc", pc, 32'h0000_0100);
    chk("redirect_instr", instr, mem_word(32'h0000_0100));

    // Redirect from REQ without grant: target valid on the third cycle after.
    gnt_pct = 0;
    repeat (4) tick();
    branch = 1'b1; branch_pc = 32'h0000_0300;
    tick();
    branch = 1'b0; gnt_pct = 100;
    wait_valid(10, n);
    chk("redirect_latency", n, 2);
    chk("redirect_pc_300", pc, 32'h0000_0300);
    repeat (4) tick();

    // Redirect to an unaligned target while three entries are queued.
    do_reset();
    r0 = rvalid_cnt; n = 0;
    while (rvalid_cnt - r0 < 3 && n < 20) begin
      tick();
      n++;
    end
    chk("three_pushed", rvalid_cnt - r0, 3);
    chk("three_head", {valid, pc}, {1'b1, 32'h0});
    branch = 1'b1; branch_pc = 32'h0000_0203;
    #1;
    chk("flush_full_fifo", {flush, valid, instr}, {1'b1, 1'b0, NOP});
    tick();
    branch = 1'b0;
    chk("fifo_cleared", {valid, instr}, {1'b0, NOP});
    ready = 1'b1;
    wait_valid(20, n);
    chk("resume_pc", pc, 32'h0000_0200);
    repeat (4) tick();

    // Asynchronous reset in WAIT with two entries queued; stale response must be ignored.
    do_reset();
    r0 = rvalid_cnt; n = 0;
    while (rvalid_cnt - r0 < 2 && n < 20) begin
      tick();
      n++;
    end
    g0 = grants;
    tick();
    chk("wait_grant", grants - g0, 1);
    chk("two_queued_head", {valid, pc}, {1'b1, 32'h0});
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_ctrl", {req, valid, flush}, {1'b0, 1'b0, 1'b1});
    chk("async_reset_addr", addr, 32'h0);
    chk("async_reset_instr_pc", {instr, pc}, {NOP, 32'h0});
    load_model(32'h0);
    hold_valid = 1'b0;
    #1 rst_n = 1'b1;
    ready = 1'b1;
    wait_valid(10, n);
    chk("post_reset_pc", pc, 32'h0);
    chk("post_reset_instr", instr, 32'h0050_0093);

    // Randomized traffic: random ready, grant delay, response latency and redirects.
    do_reset();
    gnt_pct = 60; lat_min = 0; lat_max = 2;
    p0 = pops; since = 0;
    for (int c = 0; c < 2000; c++) begin
      ready = ($urandom_range(3) != 0);
      if (branch && $urandom_range(3) == 0) branch = 1'b1;
      else branch = ($urandom_range(29) == 0) || (since > 120);
      if (branch) begin
        branch_pc = $urandom;
        since = 0;
      end else begin
        since++;
      end
      tick();
    end
    branch = 1'b0;
    repeat (10) tick();
    chk("random_pops", (pops - p0) >= 100, 1'b1);

    // Fetch address wraps past the top of memory.
    chk("wrap_addr0", d2_addr[0], 32'hFFFF_FFFC);
    chk("wrap_addr1", d2_addr[1], 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/marv32_instruction_fetch_buffer.md
Name: marv32_instruction_fetch_buffer

Overview:
Front-end fetch stage of the marv32 core and the producer side of the instruction decoder's interface. It issues word reads to instruction memory over a req/gnt/rvalid bus and queues the returned words with their PCs in a DEPTH-entry FIFO. It presents one instruction per cycle to decode, plus the flush_out/instr_out pair that drives the decoder's flush_in/instr_in. On a branch redirect it flushes the FIFO, discards any in-flight response and restarts fetch at the target.

Parameters:
DEPTH, 4, FIFO entries (power of two, >= 2)
RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)

Ports:
clk_in  input  1  core clock, rising edge
rst_n_in  input  1  asynchronous active-low reset
ready_in  input  1  decode accepts the presented instruction this cycle
branch_taken_in  input  1  redirect request from execute
branch_pc_in  input  32  redirect target; bits [1:0] ignored, treated as 0
imem_req_out  output  1  fetch request valid
imem_addr_out  output  32  fetch word address
imem_gnt_in  input  1  request accepted this cycle
imem_rvalid_in  input  1  read data valid
imem_rdata_in  input  32  read data
instr_out  output  32  instruction to decoder
pc_out  output  32  PC of instr_out
instr_valid_out  output  1  instr_out holds a real queued instruction
flush_out  output  1  to decoder flush_in; bubble this cycle

Behaviour:
- Reset (async assert, sync release): FIFO empty, fetch_pc=RESET_PC, FSM=REQ, imem_req_out=0, imem_addr_out=RESET_PC, instr_out=32'h0000_0013 (NOP), pc_out=0, instr_valid_out=0, flush_out=1.
- At most one outstanding memory request.
- FSM states:
  - REQ: imem_req_out=1 only if count+1 <= DEPTH (a free slot is reserved for the response). On gnt: fetch_pc += 4 (wraps 0xFFFF_FFFC -> 0), go to WAIT.
  - WAIT: on rvalid, push {rdata, pc}, go to REQ. Push and pop in the same cycle are both allowed, and count is unchanged.
  - DISCARD: the next rvalid is dropped, not pushed; then go to REQ.
- imem_addr_out = fetch_pc. It is held stable while req=1 and gnt=0.
- Output: when count>0, instr_out/pc_out = FIFO head (combinational from registered storage), instr_valid_out=1, flush_out=0. When empty: NOP, pc_out=0, valid=0, flush_out=1.
- Pop occurs when instr_valid_out && ready_in. No pop when ready_in=0; the head is held.
- Redirect (branch_taken_in=1) has highest priority:
  - FIFO cleared and fetch_pc <= {branch_pc_in[31:2],2'b00}. No pop or push that cycle.
  - In the same cycle flush_out=1, instr_valid_out=0 and instr_out=NOP, regardless of FIFO contents.
  - Next state:
    - WAIT with no rvalid this cycle -> DISCARD.
    - WAIT with rvalid this cycle -> data dropped, go to REQ.
    - REQ with gnt this cycle -> DISCARD.
    - Otherwise -> REQ.
  - First request at the target: imem_req_out asserted the cycle after the redirect (if not DISCARD).
- Back-to-back redirects: each reloads fetch_pc. The pending DISCARD is retained and no second discard is added.
- Full FIFO: req deasserted until a pop frees a slot. A pop in cycle N allows req in cycle N+1.
- Latency with a 1-cycle-gnt, next-cycle-rvalid memory:
  - Reset release -> first instr_valid_out after 3 cycles.
  - Redirect -> target instruction valid on cycle 3 after the redirect.

Test Plan:
- Reset then memory returns 0x00500093, 0x00A00113 for addresses 0x0, 0x4, ready_in=1 -> instr_out sequence 0x00500093 (pc 0x0), 0x00A00113 (pc 0x4), valid=1 and flush_out=0 on each.
- ready_in=0 for 10 cycles -> exactly DEPTH=4 grants (addresses 0x0–0xC), then req=0. Head stays 0x0 until ready_in=1, then pops in order and req resumes the next cycle.
- Redirect to 0x100 while WAIT, with rvalid arriving the next cycle carrying 0xDEADBEEF -> that word is discarded, next address is 0x100, flush_out=1 during the bubble, first valid pc_out=0x100.
- Redirect with branch_pc_in=0x203 while FIFO holds 3 entries -> FIFO empties the same cycle, fetch resumes at 0x200, valid=0 and instr_out=0x00000013.
- RESET_PC=0xFFFFFFFC, two fetches -> addresses 0xFFFFFFFC then 0x00000000.
- rst_n_in asserted mid-WAIT with the FIFO 2 entries full -> outputs return to reset values immediately (async). After release, the first request is to RESET_PC and the stale rvalid is ignored because the FSM is in REQ.
